uart_sync_fifo: RTL

//  Parametrised single-clock FIFO for the UART TX/RX datapaths. Generalises the
//  8x8 buffer to any width and any power-of-2 depth. Adds:
//   - selectable first-word-fall-through (FWFT) read mode
//   - fill count, almost-full/almost-empty thresholds
//   - full-and-read simultaneous write, synchronous flush
//   - sticky overflow/underflow error flags

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync_fifo_if.sv | 33 +++
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_sync_fifo.sv | 136 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FIFO defaults and threshold helper for the UART datapaths
package uart_pkg;

    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_AE_THRESH = 2;

    // at_least=1: count >= thresh (almost_full); at_least=0: count <= thresh (almost_empty)
    function automatic logic thresh_hit(input int count, input int thresh, input logic at_least);
        return at_least ? (count >= thresh) : (count <= thresh);
    endfunction

endpackage

// File: rtl/uart_sync_fifo_if.sv
// rtl/uart_sync_fifo_if.sv - FIFO access bundle; master drives requests, slave is the FIFO
interface uart_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with optional first-word-fall-through,
// fill level, almost thresholds, flush and sticky overflow/underflow.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = FIFO_AE_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    uart_sync_fifo_if.slave  fifo
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] ONE    = (AW+1)'(1);
    localparam logic        AF_RST = thresh_hit(0, AF_THRESH, 1'b1);
    localparam logic        AE_RST = thresh_hit(0, AE_THRESH, 1'b0);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ov_q, ov_d;
    logic             un_q, un_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic             rd_ok;
    logic             wr_ok;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok  = fifo.rd_en & ~empty_q;
    assign wr_ok  = fifo.wr_en & (~full_q | rd_ok);
    assign mem_we = wr_ok & ~fifo.flush;

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (fifo.wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ov_d       = ov_q;
        un_d       = un_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (fifo.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ov_d     = 1'b0;
            un_d     = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (rd_ok) begin
                rd_ptr_d   = rd_ptr_q + ONE;
                rd_valid_d = 1'b1;
                rd_data_d  = mem_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            if (fifo.wr_en & ~wr_ok) begin
                ov_d = 1'b1;
            end
            if (fifo.rd_en & empty_q) begin
                un_d = 1'b1;
            end
        end

        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        af_d    = thresh_hit(int'(count_d), AF_THRESH, 1'b1);
        ae_d    = thresh_hit(int'(count_d), AE_THRESH, 1'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= AF_RST;
            ae_q       <= AE_RST;
            ov_q       <= 1'b0;
            un_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ov_q       <= ov_d;
            un_q       <= un_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // FWFT shows the head word straight from storage; otherwise the registered copy.
    assign fifo.rd_data      = (FWFT != 0) ? mem_rdata : rd_data_q;
    assign fifo.rd_valid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
    assign fifo.full         = full_q;
    assign fifo.empty        = empty_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.count        = count_q;
    assign fifo.overflow     = ov_q;
    assign fifo.underflow    = un_q;
endmodule
